dma_read_engine: RTL

Executes one DMA read command at a time on the single-command interface driven by the read-path arbiter: dma_read_addr, dma_read_len, dma_valid and dma_done. Splits each command into memory-read requests no larger than p_mrrs_dw DWs that never cross a 4 KB boundary. Tracks outstanding requests by tag and counts returned completion DWs. Pulses dma_done once all requested data has returned.

---
 rtl/dma_read_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dma_read_engine.sv
// dma_read_engine: splits one DMA read command into tagged, 4 KB-safe memory reads and tracks completions
module dma_read_engine #(
    parameter int p_mrrs_dw  = 128,
    parameter int p_tags     = 4,
    parameter int p_tag_bits = 2,
    parameter int p_holdoff  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           dma_read_addr,
    input  logic [9:0]            dma_read_len,
    input  logic                  dma_valid,
    output logic                  dma_done,
    output logic                  dma_err,
    output logic [31:0]           req_addr,
    output logic [9:0]            req_len,
    output logic [p_tag_bits-1:0] req_tag,
    output logic                  req_valid,
    input  logic                  req_ready,
    input  logic                  cpl_valid,
    input  logic [p_tag_bits-1:0] cpl_tag,
    input  logic [10:0]           cpl_dw,
    input  logic                  cpl_last,
    input  logic                  cpl_err
);
    localparam int NT = 2 ** p_tag_bits;
    localparam int HW = $clog2(p_holdoff + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} state_t;
    state_t st_q, st_d;
    logic [31:0] cur_addr_q, cur_addr_d, req_addr_q, req_addr_d, nxt_addr;
    logic [10:0] rem_q, rem_d, tot_q, tot_d, rx_q, rx_d;
    logic [10:0] adv, nxt_rem, bnd, c0, chunk;
    logic [11:0] rx_sum;
    logic err_q, err_d, req_valid_q, req_valid_d;
    logic [NT-1:0] busy_q, busy_d, busy_a;
    logic [p_tag_bits:0] out_q, out_d, out_a;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [9:0] req_len_q, req_len_d;
    logic [p_tag_bits-1:0] req_tag_q, req_tag_d, free_tag;
    logic hs, cv, hit, retire, issue;
    always_comb begin
        hs       = req_valid_q && req_ready;
        adv      = {req_len_q == 10'd0, req_len_q};
        // the pending request's own length advances the window, so the next chunk is sized from post-handshake state
        nxt_addr = hs ? cur_addr_q + {19'd0, adv, 2'b00} : cur_addr_q;
        nxt_rem  = hs ? rem_q - adv : rem_q;
        busy_a   = busy_q | (hs ? NT'(1) << req_tag_q : '0);
        out_a    = out_q + (p_tag_bits + 1)'(hs);
        bnd      = 11'd1024 - {1'b0, nxt_addr[11:2]};
        c0       = nxt_rem < bnd ? nxt_rem : bnd;
        chunk    = c0 < 11'(p_mrrs_dw) ? c0 : 11'(p_mrrs_dw);
        free_tag = '0;
        for (int i = p_tags - 1; i >= 0; i--)
            if (!busy_a[i]) free_tag = p_tag_bits'(i);
        issue    = st_q == ISSUE && nxt_rem != 11'd0 && (!req_valid_q || hs) &&
                   out_a < (p_tag_bits + 1)'(p_tags);
        cv       = cpl_valid && (st_q == ISSUE || st_q == WAIT);
        hit      = busy_q[cpl_tag];
        retire   = cv && hit && cpl_last;
        rx_sum   = {1'b0, rx_q} + {1'b0, cpl_dw};
        st_d        = st_q;
        cur_addr_d  = nxt_addr;
        rem_d       = nxt_rem;
        tot_d       = tot_q;
        rx_d        = cv && hit ? (rx_sum[11] ? 11'h7ff : rx_sum[10:0]) : rx_q;
        err_d       = cv ? (hit ? err_q | cpl_err : 1'b1) : err_q;
        busy_d      = busy_a & ~(retire ? NT'(1) << cpl_tag : '0);
        out_d       = out_a - (p_tag_bits + 1)'(retire);
        hcnt_d      = hcnt_q;
        req_valid_d = issue || (req_valid_q && !hs);
        req_addr_d  = issue ? nxt_addr : req_addr_q;
        req_len_d   = issue ? chunk[9:0] : req_len_q;
        req_tag_d   = issue ? free_tag : req_tag_q;
        case (st_q)
            IDLE: if (dma_valid) begin
                cur_addr_d = dma_read_addr & ~32'd3;
                rem_d      = {dma_read_len == 10'd0, dma_read_len};
                tot_d      = {dma_read_len == 10'd0, dma_read_len};
                rx_d       = '0;
                err_d      = 1'b0;
                st_d       = ISSUE;
            end
            ISSUE: st_d = hs && nxt_rem == 11'd0 ? WAIT : ISSUE;
            WAIT: if (out_q == '0) begin
                st_d  = DONE;
                err_d = err_q || rx_q != tot_q;
            end
            DONE: begin
                st_d   = HOLD;
                hcnt_d = '0;
            end
            HOLD: begin
                hcnt_d = hcnt_q + HW'(1);
                st_d   = hcnt_q == HW'(p_holdoff - 1) ? IDLE : HOLD;
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_q        <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            tot_q       <= '0;
            rx_q        <= '0;
            err_q       <= 1'b0;
            busy_q      <= '0;
            out_q       <= '0;
            hcnt_q      <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_tag_q   <= '0;
        end else begin
            st_q        <= st_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            tot_q       <= tot_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            hcnt_q      <= hcnt_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_tag_q   <= req_tag_d;
        end
    end
    assign dma_done  = st_q == DONE;
    assign dma_err   = st_q == DONE && err_q;
    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;
    assign req_tag   = req_tag_q;
endmodule
